// File: rtl/fb_pkg.sv
// fb_pkg: shared frame-buffer geometry, pixel/request types and address mapping
package fb_pkg;
    localparam int H_DISPLAY = 800;
    localparam int V_DISPLAY = 600;
    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 19;

    typedef logic [DATA_W-1:0] pixel_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        pixel_t            data;
    } wr_req_t;

    // y*h + x built from shifted copies of y, one per set bit of the constant h
    function automatic logic [ADDR_W-1:0] fb_addr(input logic [10:0] x, input logic [9:0] y, input int h);
        logic [ADDR_W-1:0] acc;
        acc = ADDR_W'(x);
        for (int i = 0; i < 12; i++)
            if (h[i]) acc = acc + (ADDR_W'(y) << i);
        return acc;
    endfunction
endpackage

// File: rtl/fb_write_fifo.sv
// fb_write_fifo: small power-of-two queue holding pending frame-buffer writes
module fb_write_fifo
    import fb_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = wr_req_t
) (
    input  logic Clock,
    input  logic Reset_n,
    input  logic push_i,
    input  logic pop_i,
    input  T     data_i,
    output T     data_o,
    output logic full_o,
    output logic empty_o
);
    localparam int PW = $clog2(DEPTH);

    T               mem_q [DEPTH];
    logic [PW-1:0]  wptr_q, rptr_q;
    logic [PW:0]    cnt_q, cnt_d;
    logic           do_push, do_pop;

    assign full_o  = cnt_q == (PW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rptr_q];

    // occupancy is unchanged when a push and a pop land together
    always_comb begin
        cnt_d = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_q + PW'(do_push);
            rptr_q <= rptr_q + PW'(do_pop);
            cnt_q  <= cnt_d;
        end
    end

    // entry storage needs no reset; only occupied slots are ever read out
    always_ff @(posedge Clock) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end
endmodule

// File: rtl/frame_buffer_arbiter.sv
// frame_buffer_arbiter: shares one single-port RAM between display reads and queued draw writes
module frame_buffer_arbiter
    import fb_pkg::*;
#(
    parameter int H_DISPLAY  = fb_pkg::H_DISPLAY,
    parameter int V_DISPLAY  = fb_pkg::V_DISPLAY,
    parameter int DATA_W     = fb_pkg::DATA_W,
    parameter int ADDR_W     = fb_pkg::ADDR_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              blank_n,
    input  logic [10:0]       nextX,
    input  logic [9:0]        nextY,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [10:0]       wr_x,
    input  logic [9:0]        wr_y,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid
);
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] pix_q, pix_d;
    logic              ready_q, err_q, err_d, v1_q, pix_valid_q;
    logic              full, empty, accept, in_range, push, pop;
    wr_req_t           head, entry;

    assign in_range = (wr_x < 11'(H_DISPLAY)) && (wr_y < 10'(V_DISPLAY));
    assign wr_ready = ready_q & ~full;
    assign accept   = wr_valid & wr_ready;
    assign push     = accept & in_range;
    assign pop      = ~blank_n & ~empty;
    assign entry    = '{addr: fb_addr(wr_x, wr_y, H_DISPLAY), data: wr_data};

    fb_write_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (wr_req_t)
    ) u_fifo (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (entry),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    // display read always wins; blanking drains one write; otherwise the address holds
    always_comb begin
        addr_d = blank_n ? fb_addr(nextX, nextY, H_DISPLAY) : pop ? head.addr : addr_q;
        err_d  = accept & ~in_range;
        pix_d  = v1_q ? mem_rdata : '0;
    end

    // RAM port is forced idle while reset is asserted so no write can slip out
    assign mem_addr  = Reset_n ? addr_d : '0;
    assign mem_we    = Reset_n & pop;
    assign mem_wdata = (Reset_n & pop) ? head.data : '0;
    assign wr_err    = err_q;
    assign pix_data  = pix_q;
    assign pix_valid = pix_valid_q;

    // two-stage display pipeline (RAM latency + output register) and write-side status
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            addr_q      <= '0;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
            v1_q        <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_q       <= '0;
        end else begin
            addr_q      <= addr_d;
            ready_q     <= 1'b1;
            err_q       <= err_d;
            v1_q        <= blank_n;
            pix_valid_q <= v1_q;
            pix_q       <= pix_d;
        end
    end
endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// tb_frame_buffer_arbiter: directed plus random stimulus against a queue/array reference model
module tb_frame_buffer_arbiter;
    logic        Clock = 1'b0, Reset_n = 1'b1;
    logic        blank_n = 1'b1, wr_valid = 1'b0;
    logic [10:0] nextX = 11'd3, wr_x = '0;
    logic [9:0]  nextY = '0, wr_y = '0;
    logic [7:0]  wr_data = '0, mem_rdata = '0;
    logic        wr_ready, wr_err, mem_we, pix_valid;
    logic [18:0] mem_addr;
    logic [7:0]  mem_wdata, pix_data;

    bit [7:0]    ram   [0:524287];
    bit          wflag [0:524287];
    logic [7:0]  fb    [0:524287];

    typedef struct { int addr; logic [7:0] d; } ent_t;
    ent_t        q[$];
    int          n_chk = 0, n_fail = 0, last_addr = 0, cnt;
    bit          rdy_ok, acc, e_err, s1v, s2v;
    logic [7:0]  s1d, s2d;

    frame_buffer_arbiter dut (
        .Clock(Clock), .Reset_n(Reset_n), .blank_n(blank_n), .nextX(nextX), .nextY(nextY),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
        .wr_err(wr_err), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .pix_data(pix_data), .pix_valid(pix_valid)
    );

    always #5 Clock = ~Clock;

    function automatic logic [7:0] pat(int a);
        return 8'(a * 13 + (a >> 7));
    endfunction

    // single-port RAM, one-cycle read latency, read-before-write
    always @(posedge Clock) begin
        mem_rdata <= wflag[mem_addr] ? ram[mem_addr] : pat(int'(mem_addr));
        if (mem_we) begin
            ram[mem_addr]   <= mem_wdata;
            wflag[mem_addr] <= 1'b1;
        end
    end

    task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
        n_chk++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, o, e);
        end
    endtask

    task automatic out_zero(string tag);
        chk({tag, "_we"}, 32'(mem_we), 0);
        chk({tag, "_addr"}, 32'(mem_addr), 0);
        chk({tag, "_wdata"}, 32'(mem_wdata), 0);
        chk({tag, "_pix"}, 32'(pix_data), 0);
        chk({tag, "_pixv"}, 32'(pix_valid), 0);
        chk({tag, "_err"}, 32'(wr_err), 0);
        chk({tag, "_ready"}, 32'(wr_ready), 0);
    endtask

    // one clock: compare DUT against the model, advance the model, step to next negedge
    task automatic cyc();
        int ea;
        bit er, ew;
        logic [7:0] rv;
        #1;
        er = rdy_ok && q.size() < 4;
        ew = !blank_n && q.size() != 0;
        if (blank_n) ea = int'(nextY) * 800 + int'(nextX);
        else if (ew) ea = q[0].addr;
        else ea = last_addr;
        chk("wr_ready", 32'(wr_ready), 32'(er));
        chk("mem_we", 32'(mem_we), 32'(ew));
        chk("mem_addr", 32'(mem_addr), ea);
        if (ew) chk("mem_wdata", 32'(mem_wdata), 32'(q[0].d));
        chk("pix_valid", 32'(pix_valid), 32'(s2v));
        chk("pix_data", 32'(pix_data), 32'(s2d));
        chk("wr_err", 32'(wr_err), 32'(e_err));
        rv = fb[ea];
        if (ew) begin
            fb[q[0].addr] = q[0].d;
            void'(q.pop_front());
        end
        acc   = wr_valid && er;
        e_err = acc && !(wr_x < 800 && wr_y < 600);
        if (acc && !e_err) q.push_back('{int'(wr_y) * 800 + int'(wr_x), wr_data});
        last_addr = ea;
        s2v = s1v; s2d = s1d;
        s1v = blank_n; s1d = blank_n ? rv : 8'h00;
        rdy_ok = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic wr_until(int x, int y, int d);
        wr_valid = 1'b1; wr_x = 11'(x); wr_y = 10'(y); wr_data = 8'(d);
        acc = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            if (acc) break;
        end
        chk("wr_accept", 32'(acc), 1);
        wr_valid = 1'b0;
    endtask

    task automatic do_reset();
        #2 Reset_n = 1'b0;
        #1 out_zero("rst_async");
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        #1 out_zero("rst_hold");
        Reset_n = 1'b1;
        q.delete();
        s1v = 0; s2v = 0; s1d = 0; s2d = 0; e_err = 0; last_addr = 0; rdy_ok = 0;
    endtask

    task automatic post_reset();
        #1 chk("ready_at_release", 32'(wr_ready), 0);
        cyc();
        #1 chk("ready_first_edge", 32'(wr_ready), 1);
        cyc();
    endtask

    initial begin
        for (int i = 0; i < 524288; i++) fb[i] = pat(i);
        do_reset();
        blank_n = 1'b0;
        post_reset();

        nextY = 10'd5;
        cnt = 0;
        for (int i = 0; i < 803; i++) begin
            blank_n = (i < 800);
            nextX = 11'(i < 800 ? i : 0);
            if (i == 0 || i == 799) begin
                #1 chk("line_addr", 32'(mem_addr), 32'(4000 + i));
            end
            cyc();
            cnt += int'(pix_valid);
        end
        chk("line_pix_count", cnt, 800);

        blank_n = 1'b1; nextX = '0; nextY = '0;
        wr_until(10, 2, 'hAB);
        repeat (3) cyc();
        blank_n = 1'b0;
        #1 chk("wa_we", 32'(mem_we), 1);
        chk("wa_addr", 32'(mem_addr), 1610);
        chk("wa_wdata", 32'(mem_wdata), 'hAB);
        cyc();
        #1 chk("hold_addr", 32'(mem_addr), 1610);
        chk("hold_we", 32'(mem_we), 0);
        cyc();

        blank_n = 1'b1; nextX = 11'd100; nextY = 10'd7;
        for (int k = 0; k < 4; k++) wr_until(k, 1, 'h10 + k);
        wr_valid = 1'b1; wr_x = 11'd4; wr_y = 10'd1; wr_data = 8'h14;
        repeat (4) begin
            #1 chk("full_ready", 32'(wr_ready), 0);
            cyc();
        end
        blank_n = 1'b0;
        #1 chk("full_drain_we", 32'(mem_we), 1);
        chk("full_drain_addr", 32'(mem_addr), 800);
        chk("full_drain_ready", 32'(wr_ready), 0);
        cyc();
        #1 chk("full_ready_after", 32'(wr_ready), 1);
        cyc();
        chk("full_5th_acc", 32'(acc), 1);
        wr_valid = 1'b0;
        repeat (6) cyc();

        wr_valid = 1'b1; wr_x = 11'd800; wr_y = '0; wr_data = 8'h55;
        #1 chk("oor_ready", 32'(wr_ready), 1);
        cyc();
        chk("oor_acc", 32'(acc), 1);
        wr_valid = 1'b0;
        #1 chk("oor_err_hi", 32'(wr_err), 1);
        chk("oor_no_we", 32'(mem_we), 0);
        cyc();
        #1 chk("oor_err_lo", 32'(wr_err), 0);
        cyc();

        blank_n = 1'b1;
        wr_until(20, 3, 'hC1);
        wr_until(21, 3, 'hC2);
        blank_n = 1'b0;
        wr_valid = 1'b1; wr_x = 11'd22; wr_y = 10'd3; wr_data = 8'hC3;
        #1 chk("pp_we", 32'(mem_we), 1);
        chk("pp_addr", 32'(mem_addr), 2420);
        chk("pp_ready", 32'(wr_ready), 1);
        cyc();
        chk("pp_acc", 32'(acc), 1);
        blank_n = 1'b1;
        wr_until(23, 3, 'hC4);
        wr_until(24, 3, 'hC5);
        wr_valid = 1'b1; wr_x = 11'd25; wr_y = 10'd3; wr_data = 8'hC6;
        #1 chk("pp_full", 32'(wr_ready), 0);
        cyc();
        blank_n = 1'b0;
        #1 chk("pp_oldest", 32'(mem_addr), 2421);
        repeat (2) cyc();
        wr_valid = 1'b0;
        repeat (8) cyc();

        blank_n = 1'b1;
        for (int k = 0; k < 3; k++) wr_until(30 + k, 4, 'hE0 + k);
        blank_n = 1'b0;
        do_reset();
        post_reset();
        for (int k = 0; k < 6; k++) begin
            #1 chk("rst_no_write", 32'(mem_we), 0);
            cyc();
        end

        blank_n = 1'b0;
        wr_valid = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            if ($urandom_range(0, 15) == 0) blank_n = ~blank_n;
            nextX = 11'($urandom_range(0, 799));
            nextY = 10'($urandom_range(0, 599));
            if (!wr_valid && $urandom_range(0, 2) == 0) begin
                wr_valid = 1'b1;
                wr_x = ($urandom_range(0, 15) == 0) ? 11'($urandom_range(800, 2047)) : 11'($urandom_range(0, 799));
                wr_y = ($urandom_range(0, 15) == 0) ? 10'($urandom_range(600, 1023)) : 10'($urandom_range(0, 599));
                wr_data = 8'($urandom);
            end
            cyc();
            if (acc) wr_valid = 1'b0;
        end
        blank_n = 1'b0;
        wr_valid = 1'b0;
        repeat (8) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
